ifetch_queue: RTL

Instruction-fetch queue between the PC unit and decode. Takes one PC at a time from the PC unit and issues a word read to instruction memory with a req/ack handshake. Stores each returned instruction with its PC in a show-ahead FIFO that decode drains. A flush input discards all queued and in-flight instructions when the PC is redirected by a jump, branch, or register jump.

---
 rtl/ifetch_queue_if.sv | 32 +++
 rtl/ifetch_queue.sv | 95 +++++++++
 2 files changed

// File: rtl/ifetch_queue_if.sv
// Handshake bundle between the PC unit, instruction memory and decode
// for the instruction-fetch queue.
interface ifetch_queue_if #(
  parameter int W_CPU = 32,
  parameter int DEPTH = 4
);
  logic [W_CPU-1:0]         pc_in;
  logic                     pc_valid;
  logic                     pc_ready;
  logic                     imem_req;
  logic [W_CPU-1:0]         imem_addr;
  logic                     imem_ack;
  logic [W_CPU-1:0]         imem_rdata;
  logic                     flush;
  logic                     dec_valid;
  logic                     dec_ready;
  logic [W_CPU-1:0]         dec_instr;
  logic [W_CPU-1:0]         dec_pc;
  logic [$clog2(DEPTH):0]   count;

  // the queue itself
  modport slave (
    input  pc_in, pc_valid, imem_ack, imem_rdata, flush, dec_ready,
    output pc_ready, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, count
  );

  // PC unit, memory and decode as seen from outside the queue
  modport master (
    output pc_in, pc_valid, imem_ack, imem_rdata, flush, dec_ready,
    input  pc_ready, imem_req, imem_addr, dec_valid, dec_instr, dec_pc, count
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: one outstanding word read to instruction memory,
// responses stored with their PC in a show-ahead FIFO drained by decode.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request outstanding, response will be stored
// DRAIN | request outstanding, response will be dropped (flushed)
module ifetch_queue #(
  parameter int W_CPU = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t           state, state_nx;
  logic             req_q;
  logic [W_CPU-1:0] addr_q;
  logic [W_CPU-1:0] pc_lat;
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count_q;
  logic [W_CPU-1:0] instr_mem [DEPTH];
  logic [W_CPU-1:0] pc_mem    [DEPTH];

  logic pc_ready, accept, push, pop, dec_valid;

  assign pc_ready  = (state == IDLE) && (count_q < DEPTH_C) && !bus.flush && !rst;
  assign accept    = bus.pc_valid && pc_ready;
  assign push      = (state == WAIT) && bus.imem_ack && !bus.flush;
  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid && bus.dec_ready && !bus.flush;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = WAIT;
      WAIT: begin
        if (bus.flush)         state_nx = bus.imem_ack ? IDLE : DRAIN;
        else if (bus.imem_ack) state_nx = IDLE;
      end
      DRAIN:   if (bus.imem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      pc_lat  <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      state <= state_nx;
      // request stays up for as long as a response is owed
      req_q <= (state_nx != IDLE);
      if (accept) begin
        pc_lat <= bus.pc_in;
        addr_q <= {bus.pc_in[W_CPU-1:2], 2'b00};
      end
      if (bus.flush) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        if (push && !pop)      count_q <= count_q + (PW+1)'(1);
        else if (pop && !push) count_q <= count_q - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= bus.imem_rdata;
      pc_mem[tail]    <= pc_lat;
    end
  end

  assign bus.pc_ready  = pc_ready;
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.dec_valid = dec_valid;
  assign bus.dec_instr = instr_mem[head];
  assign bus.dec_pc    = pc_mem[head];
  assign bus.count     = count_q;
endmodule
